// File: rtl/sha256_msg_padder_if.sv
// Block stream between the message padder and the SHA-256 compression core.
interface sha256_msg_padder_if;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_data;
    logic [3:0]  blk_word_idx;
    logic        blk_last_block;

    modport master (
        output blk_valid,
        output blk_data,
        output blk_word_idx,
        output blk_last_block,
        input  blk_ready
    );

    modport slave (
        input  blk_valid,
        input  blk_data,
        input  blk_word_idx,
        input  blk_last_block,
        output blk_ready
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: reads a big-endian message from word memory and streams it,
// followed by SHA-256 padding, as 16-word blocks on a valid/ready stream.
// Optional byte-granular message length: define SHA_PAD_BYTE_LEN_EN.
module sha256_msg_padder #(
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned BLK_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [15:0]          message_addr,
    input  logic [15:0]          num_words,
`ifdef SHA_PAD_BYTE_LEN_EN
    input  logic [17:0]          msg_bytes,
`endif
    output logic                 done,
    output logic                 mem_clk,
    output logic                 mem_we,
    output logic [15:0]          mem_addr,
    input  logic [31:0]          mem_read_data,
    output logic [BLK_CNT_W-1:0] num_blocks,
    sha256_msg_padder_if.master  blk
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BYTE_W = 18;
    localparam logic [31:0] MARKER = 32'h8000_0000;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, HOLD, PAD} state_t;

    state_t             state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   blocks_q, blocks_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [31:0]        len_q, len_d;
    logic [1:0]         rem_q, rem_d;
    logic [31:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   n_start, blocks_start, total_words, nxt_idx;
    logic [31:0]        len_start, pad_data, rd_data;
    logic [1:0]         rem_start;
    logic               accept;

`ifdef SHA_PAD_BYTE_LEN_EN
    logic [BYTE_W-1:0]  bytes_clamped;
    logic               unused_num_words;
    assign unused_num_words = ^num_words;

    // Clamp the byte length; derive word count, block count, bit length and tail bytes.
    always_comb begin
        bytes_clamped = (msg_bytes > BYTE_W'(4 * MAX_WORDS)) ? BYTE_W'(4 * MAX_WORDS) : msg_bytes;
        n_start       = CNT_W'((bytes_clamped + BYTE_W'(3)) >> 2);
        blocks_start  = CNT_W'(((bytes_clamped + BYTE_W'(8)) >> 6) + BYTE_W'(1));
        len_start     = 32'(bytes_clamped) << 3;
        rem_start     = bytes_clamped[1:0];
    end
`else
    // Clamp the word length; derive block count and bit length.
    always_comb begin
        n_start      = (num_words > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : num_words;
        blocks_start = ((n_start + CNT_W'(2)) >> 4) + CNT_W'(1);
        len_start    = 32'(n_start) << 5;
        rem_start    = 2'd0;
    end
`endif

    assign total_words = blocks_q << 4;
    assign nxt_idx     = out_cnt_q + CNT_W'(1);
    assign accept      = valid_q && blk.blk_ready;

    // Pad word following the current one: length low word, stand-alone marker, or zero.
    always_comb begin
        pad_data = 32'd0;
        if (nxt_idx == total_words - CNT_W'(1)) begin
            pad_data = len_q;
        end else if (nxt_idx == n_q && rem_q == 2'd0) begin
            pad_data = MARKER;
        end
    end

    // Memory word; a partial trailing word is truncated and carries the marker in place.
    always_comb begin
        rd_data = mem_read_data;
        if (rem_q != 2'd0 && rd_cnt_q == n_q) begin
            rd_data = (mem_read_data & ~(32'hFFFF_FFFF >> {rem_q, 3'b000}))
                    | (MARKER >> {rem_q, 3'b000});
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        n_d        = n_q;
        blocks_d   = blocks_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        len_d      = len_q;
        rem_d      = rem_q;
        data_d     = data_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = message_addr;
                    n_d       = n_start;
                    blocks_d  = blocks_start;
                    len_d     = len_start;
                    rem_d     = rem_start;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    if (n_start == '0) begin
                        state_d = PAD;
                        valid_d = 1'b1;
                        data_d  = MARKER;
                    end else begin
                        state_d    = RD_REQ;
                        mem_addr_d = message_addr;
                    end
                end
            end
            RD_REQ: begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                data_d  = rd_data;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    out_cnt_d = nxt_idx;
                    if (rd_cnt_q < n_q) begin
                        state_d    = RD_REQ;
                        valid_d    = 1'b0;
                        mem_addr_d = addr_q + rd_cnt_q;
                    end else begin
                        state_d = PAD;
                        data_d  = pad_data;
                    end
                end
            end
            PAD: begin
                if (accept) begin
                    out_cnt_d = nxt_idx;
                    if (nxt_idx == total_words) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        data_d = pad_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        last_d = ((out_cnt_d >> 4) == (blocks_d - CNT_W'(1)));
        done_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            n_q        <= '0;
            blocks_q   <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            n_q        <= n_d;
            blocks_q   <= blocks_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    assign mem_clk            = clk;
    assign mem_we             = 1'b0;
    assign mem_addr           = mem_addr_q;
    assign done               = done_q;
    assign num_blocks         = BLK_CNT_W'(blocks_q);
    assign blk.blk_valid      = valid_q;
    assign blk.blk_data       = data_q;
    assign blk.blk_word_idx   = out_cnt_q[3:0];
    assign blk.blk_last_block = last_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder against a byte-level SHA-256 padding model.
module tb_sha256_msg_padder;
    localparam int unsigned MAX_WORDS = 4096;
    localparam int unsigned BLK_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [15:0]          message_addr;
    logic [15:0]          num_words;
`ifdef SHA_PAD_BYTE_LEN_EN
    logic [17:0]          msg_bytes;
`endif
    logic                 done;
    logic                 mem_clk;
    logic                 mem_we;
    logic [15:0]          mem_addr;
    logic [31:0]          mem_read_data;
    logic [BLK_CNT_W-1:0] num_blocks;

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.MAX_WORDS(MAX_WORDS), .BLK_CNT_W(BLK_CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .message_addr  (message_addr),
        .num_words     (num_words),
`ifdef SHA_PAD_BYTE_LEN_EN
        .msg_bytes     (msg_bytes),
`endif
        .done          (done),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_read_data (mem_read_data),
        .num_blocks    (num_blocks),
        .blk           (bus.master)
    );

    logic [31:0] mem [0:65535];
    logic [31:0] exp_q [$];
    int          vectors;
    int          miscompares;

    always #5 clk = ~clk;

    // Synchronous read memory: data for the address seen at the previous edge.
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    // Reference: padded byte stream (message, 0x80, zeros to 56 mod 64, 64-bit length).
    task automatic build_expected(input logic [15:0] addr, input int unsigned nbytes);
        byte unsigned bq [$];
        logic [31:0]  w;
        logic [63:0]  bitlen;
        exp_q.delete();
        for (int i = 0; i < int'(nbytes); i++) begin
            w = mem[16'(int'(addr) + i / 4)];
            bq.push_back(w[31 - 8 * (i % 4) -: 8]);
        end
        bq.push_back(8'h80);
        while (bq.size() % 64 != 56) bq.push_back(8'h00);
        bitlen = 64'(nbytes) * 64'd8;
        for (int k = 7; k >= 0; k--) bq.push_back(bitlen[8 * k +: 8]);
        for (int i = 0; i < bq.size(); i += 4) exp_q.push_back({bq[i], bq[i+1], bq[i+2], bq[i+3]});
    endtask

    task automatic fill(input logic [15:0] addr, input int unsigned n, input bit rnd);
        for (int i = 0; i < int'(n); i++) mem[16'(int'(addr) + i)] = rnd ? $urandom : 32'(i + 1);
    endtask

    task automatic kick(input logic [15:0] addr, input int unsigned units, input bit is_bytes);
        @(negedge clk);
        message_addr = addr;
`ifdef SHA_PAD_BYTE_LEN_EN
        num_words    = 16'($urandom);
        msg_bytes    = is_bytes ? 18'(units) : 18'(units * 4);
`else
        num_words    = is_bytes ? 16'((units + 3) / 4) : 16'(units);
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_msg(input logic [15:0] addr, input int unsigned units, input bit is_bytes,
                           input bit rand_ready, input bit stray, input string name);
        int unsigned nbytes, total, got, cycles, budget, stall_left;
        bit          stall_done, held, addr_moved;
        logic [31:0] h_data;
        logic [3:0]  h_idx;
        logic        h_last, exp_last;
        logic [15:0] addr0;
        if (is_bytes) nbytes = (units > 4 * MAX_WORDS) ? 4 * MAX_WORDS : units;
        else          nbytes = 4 * ((units > MAX_WORDS) ? MAX_WORDS : units);
        build_expected(addr, nbytes);
        total = exp_q.size();
        addr0 = mem_addr;
        kick(addr, units, is_bytes);
        vectors++;
        if (num_blocks !== BLK_CNT_W'(total / 16)) begin
            miscompares++;
            $display("FAIL %s num_blocks: got %0d want %0d", name, num_blocks, total / 16);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_low: got %b want 0", name, done);
        end
        got = 0; cycles = 0; stall_left = 0; stall_done = 0; held = 0; addr_moved = 0;
        budget = total * 20 + 100;
        while (got < total && cycles < budget) begin
            start = 1'b0;
            if (!rand_ready) begin
                bus.blk_ready = 1'b1;
            end else begin
                if (!stall_done && got == 8) begin stall_left = 5; stall_done = 1; end
                if (stall_left > 0) begin bus.blk_ready = 1'b0; stall_left--; end
                else bus.blk_ready = 1'($urandom_range(0, 1));
            end
            if (held) begin
                vectors++;
                if (bus.blk_valid !== 1'b1 || bus.blk_data !== h_data ||
                    bus.blk_word_idx !== h_idx || bus.blk_last_block !== h_last) begin
                    miscompares++;
                    $display("FAIL %s stall_hold word %0d: got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                             name, got, bus.blk_valid, bus.blk_data, bus.blk_word_idx,
                             bus.blk_last_block, h_data, h_idx, h_last);
                end
            end
            if (bus.blk_valid === 1'b1 && bus.blk_ready === 1'b1) begin
                exp_last = ((got / 16) == (total / 16 - 1));
                vectors += 3;
                if (bus.blk_data !== exp_q[got]) begin
                    miscompares++;
                    $display("FAIL %s data word %0d: got %h want %h", name, got, bus.blk_data, exp_q[got]);
                end
                if (bus.blk_word_idx !== 4'(got % 16)) begin
                    miscompares++;
                    $display("FAIL %s word_idx word %0d: got %0d want %0d", name, got, bus.blk_word_idx, got % 16);
                end
                if (bus.blk_last_block !== exp_last) begin
                    miscompares++;
                    $display("FAIL %s last_block word %0d: got %b want %b", name, got, bus.blk_last_block, exp_last);
                end
                got++;
            end
            held   = (bus.blk_valid === 1'b1) && (bus.blk_ready === 1'b0);
            h_data = bus.blk_data;
            h_idx  = bus.blk_word_idx;
            h_last = bus.blk_last_block;
            if (nbytes == 0 && mem_addr !== addr0) addr_moved = 1;
            if (stray && got + 3 < total && $urandom_range(0, 5) == 0) begin
                start        = 1'b1;
                message_addr = 16'($urandom);
                num_words    = 16'($urandom_range(0, 60));
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        bus.blk_ready = 1'b0;
        vectors++;
        if (got != total) begin
            miscompares++;
            $display("FAIL %s timeout: got %0d words want %0d", name, got, total);
        end
        vectors += 2;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_high: got %b want 1", name, done);
        end
        if (bus.blk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s valid_after: got %b want 0", name, bus.blk_valid);
        end
        if (nbytes == 0) begin
            vectors++;
            if (addr_moved) begin
                miscompares++;
                $display("FAIL %s no_read: mem_addr %h moved from %h", name, mem_addr, addr0);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors += 7;
        if (done !== 1'b1)              begin miscompares++; $display("FAIL %s done: got %b want 1", name, done); end
        if (bus.blk_valid !== 1'b0)     begin miscompares++; $display("FAIL %s valid: got %b want 0", name, bus.blk_valid); end
        if (bus.blk_data !== 32'd0)     begin miscompares++; $display("FAIL %s data: got %h want 0", name, bus.blk_data); end
        if (bus.blk_word_idx !== 4'd0)  begin miscompares++; $display("FAIL %s word_idx: got %0d want 0", name, bus.blk_word_idx); end
        if (bus.blk_last_block !== 1'b0) begin miscompares++; $display("FAIL %s last: got %b want 0", name, bus.blk_last_block); end
        if (mem_addr !== 16'd0)         begin miscompares++; $display("FAIL %s mem_addr: got %h want 0", name, mem_addr); end
        if (num_blocks !== '0)          begin miscompares++; $display("FAIL %s num_blocks: got %0d want 0", name, num_blocks); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        vectors++;
        if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset mem_we: got %b want 0", mem_we); end
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_release");
    endtask

    task automatic test_basic();
        fill(16'h0000, 20, 1'b0);
        run_msg(16'h0000, 20, 1'b0, 1'b0, 1'b0, "basic20");
    endtask

    task automatic test_boundaries();
        int unsigned lens [8] = '{13, 14, 15, 16, 0, 1, 29, 32};
        foreach (lens[k]) begin
            fill(16'h2000, lens[k], 1'b1);
            run_msg(16'h2000, lens[k], 1'b0, 1'b0, 1'b0, $sformatf("len%0d", lens[k]));
        end
        fill(16'h8000, MAX_WORDS, 1'b1);
        run_msg(16'h8000, 5000, 1'b0, 1'b0, 1'b0, "clamp");
    endtask

    task automatic test_backpressure();
        fill(16'h0000, 20, 1'b0);
        run_msg(16'h0000, 20, 1'b0, 1'b1, 1'b1, "stall20");
    endtask

    task automatic test_random();
        logic [15:0] a;
        int unsigned n;
        for (int k = 0; k < 8; k++) begin
            a = 16'($urandom);
            n = $urandom_range(0, 40);
            fill(a, n, 1'b1);
            run_msg(a, n, 1'b0, 1'b1, 1'b0, $sformatf("rand%0d_n%0d", k, n));
        end
    endtask

`ifdef SHA_PAD_BYTE_LEN_EN
    task automatic test_byte_len();
        int unsigned b;
        mem[16'h0100] = 32'h6162_6364;
        mem[16'h0101] = 32'h65FF_FFFF;
        run_msg(16'h0100, 5, 1'b1, 1'b0, 1'b0, "bytes5");
        for (int k = 0; k < 8; k++) begin
            b = $urandom_range(0, 130);
            fill(16'h3000, (b + 3) / 4, 1'b1);
            run_msg(16'h3000, b, 1'b1, 1'b1, 1'b0, $sformatf("bytes_rand%0d_b%0d", k, b));
        end
    endtask
`endif

    task automatic test_reset_mid();
        fill(16'h0000, 20, 1'b0);
`ifdef SHA_PAD_BYTE_LEN_EN
        kick(16'h0100, 5, 1'b1);
`else
        kick(16'h0000, 20, 1'b0);
`endif
        bus.blk_ready = 1'b1;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("reset_mid");
        @(negedge clk);
        bus.blk_ready = 1'b0;
        reset_n = 1'b1;
        run_msg(16'h0000, 20, 1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset_n       = 1'b0;
        start         = 1'b0;
        message_addr  = '0;
        num_words     = '0;
        bus.blk_ready = 1'b0;
`ifdef SHA_PAD_BYTE_LEN_EN
        msg_bytes     = '0;
`endif
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_random();
`ifdef SHA_PAD_BYTE_LEN_EN
        test_byte_len();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
